// File: rtl/dp_bram_pipe_if.sv
// Bus bundle for dp_bram_pipe: both RAM ports plus collision status.
// The master drives requests and write data; the slave (the RAM) returns
// read data, valids and collision status.
interface dp_bram_pipe_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned B  = 16,
  parameter int unsigned CW = 8
);
  localparam int unsigned NByte = B / 8;

  // Port A
  logic             ena;
  logic             rea;
  logic [NByte-1:0] wea;
  logic [N-1:0]     addra;
  logic [B-1:0]     dia;
  logic [B-1:0]     doa;
  logic             vala;

  // Port B
  logic             enb;
  logic             reb;
  logic [NByte-1:0] web;
  logic [N-1:0]     addrb;
  logic [B-1:0]     dib;
  logic [B-1:0]     dob;
  logic             valb;

  // Collision status
  logic             coll;
  logic [CW-1:0]    coll_cnt;

  modport master (
    output ena, rea, wea, addra, dia,
    output enb, reb, web, addrb, dib,
    input  doa, vala, dob, valb, coll, coll_cnt
  );

  modport slave (
    input  ena, rea, wea, addra, dia,
    input  enb, reb, web, addrb, dib,
    output doa, vala, dob, valb, coll, coll_cnt
  );

endinterface

// File: rtl/dp_bram_pipe.sv
// Single-clock true dual-port RAM with byte write enables, 1- or 2-cycle
// qualified read latency, selectable same-port read-during-write behaviour
// and write-collision detection with a saturating counter.
module dp_bram_pipe #(
  parameter int unsigned N        = 8,
  parameter int unsigned B        = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  dp_bram_pipe_if.slave   bus
);

  localparam int unsigned NByte = B / 8;
  localparam int unsigned Depth = 2 ** N;

  if (!((RD_LAT == 1) || (RD_LAT == 2))) begin : g_bad_rd_lat
    $error("dp_bram_pipe: RD_LAT must be 1 or 2");
  end
  if ((B == 0) || ((B % 8) != 0)) begin : g_bad_width
    $error("dp_bram_pipe: B must be a non-zero multiple of 8");
  end

  // Storage is deliberately not reset; contents survive rst_n.
  logic [B-1:0] mem_q [Depth];

  logic             rd_acc_a, rd_acc_b;
  logic [NByte-1:0] wr_lane_a, wr_lane_b, wr_lane_b_eff;
  logic             same_addr, coll_det;
  logic [B-1:0]     rd_word_a, rd_word_b;

  // Read pipeline and status state
  logic         s1_val_a_q, s1_val_a_d, s1_val_b_q, s1_val_b_d;
  logic [B-1:0] s1_dat_a_q, s1_dat_a_d, s1_dat_b_q, s1_dat_b_d;
  logic         vala_q, vala_d, valb_q, valb_d;
  logic [B-1:0] doa_q, doa_d, dob_q, dob_d;
  logic         coll_q, coll_d;
  logic [CW-1:0] coll_cnt_q, coll_cnt_d;

  // Accept decode, lane arbitration and read-word selection
  always_comb begin
    rd_acc_a  = bus.ena & bus.rea;
    rd_acc_b  = bus.enb & bus.reb;
    // Writes are blocked while reset is held so no edge corrupts the array.
    wr_lane_a = bus.wea & {NByte{bus.ena & rst_n}};
    wr_lane_b = bus.web & {NByte{bus.enb & rst_n}};
    same_addr = (bus.addra == bus.addrb);
    // Port A wins any lane both ports write at the same address.
    wr_lane_b_eff = wr_lane_b & ~(wr_lane_a & {NByte{same_addr}});
    coll_det  = bus.ena & bus.enb & same_addr & ((|bus.wea) | (|bus.web));

    // Cross-port reads always see the old word; only own-port lanes merge.
    rd_word_a = mem_q[bus.addra];
    rd_word_b = mem_q[bus.addrb];
    if (RDW_MODE == 1) begin
      for (int i = 0; i < int'(NByte); i++) begin
        if (wr_lane_a[i]) rd_word_a[i*8 +: 8] = bus.dia[i*8 +: 8];
        if (wr_lane_b[i]) rd_word_b[i*8 +: 8] = bus.dib[i*8 +: 8];
      end
    end
  end

  // Byte-lane writes into the array
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NByte); i++) begin
      if (wr_lane_a[i]) mem_q[bus.addra][i*8 +: 8] <= bus.dia[i*8 +: 8];
      if (wr_lane_b_eff[i]) mem_q[bus.addrb][i*8 +: 8] <= bus.dib[i*8 +: 8];
    end
  end

  // Next-state for read pipelines and collision tracking
  always_comb begin
    s1_val_a_d = rd_acc_a;
    s1_val_b_d = rd_acc_b;
    s1_dat_a_d = rd_acc_a ? rd_word_a : s1_dat_a_q;
    s1_dat_b_d = rd_acc_b ? rd_word_b : s1_dat_b_q;

    if (RD_LAT == 1) begin
      vala_d = rd_acc_a;
      valb_d = rd_acc_b;
      doa_d  = rd_acc_a ? rd_word_a : doa_q;
      dob_d  = rd_acc_b ? rd_word_b : dob_q;
    end else begin
      // Extra output register stage; outputs hold when nothing completes.
      vala_d = s1_val_a_q;
      valb_d = s1_val_b_q;
      doa_d  = s1_val_a_q ? s1_dat_a_q : doa_q;
      dob_d  = s1_val_b_q ? s1_dat_b_q : dob_q;
    end

    coll_d     = coll_det;
    coll_cnt_d = coll_cnt_q;
    if (coll_det && (coll_cnt_q != {CW{1'b1}})) begin
      coll_cnt_d = coll_cnt_q + CW'(1);
    end
  end

  // State registers; reset discards any in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_a_q <= 1'b0;
      s1_val_b_q <= 1'b0;
      s1_dat_a_q <= '0;
      s1_dat_b_q <= '0;
      vala_q     <= 1'b0;
      valb_q     <= 1'b0;
      doa_q      <= '0;
      dob_q      <= '0;
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      s1_val_a_q <= s1_val_a_d;
      s1_val_b_q <= s1_val_b_d;
      s1_dat_a_q <= s1_dat_a_d;
      s1_dat_b_q <= s1_dat_b_d;
      vala_q     <= vala_d;
      valb_q     <= valb_d;
      doa_q      <= doa_d;
      dob_q      <= dob_d;
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign bus.doa      = doa_q;
  assign bus.vala     = vala_q;
  assign bus.dob      = dob_q;
  assign bus.valb     = valb_q;
  assign bus.coll     = coll_q;
  assign bus.coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_dp_bram_pipe.sv
// Directed bench: two RAM instances share one stimulus stream.
// u1: RD_LAT=1, read-first.  u2: RD_LAT=2, write-first.
module tb_dp_bram_pipe;

  logic        clk;
  logic        rst_n;
  logic        ena, rea, enb, reb;
  logic [1:0]  wea, web;
  logic [7:0]  addra, addrb;
  logic [15:0] dia, dib;

  int n_cmp = 0;
  int n_err = 0;

  dp_bram_pipe_if #(.N(8), .B(16), .CW(8)) if1 ();
  dp_bram_pipe_if #(.N(8), .B(16), .CW(8)) if2 ();

  assign if1.ena = ena;  assign if1.rea = rea;  assign if1.wea = wea;
  assign if1.addra = addra;  assign if1.dia = dia;
  assign if1.enb = enb;  assign if1.reb = reb;  assign if1.web = web;
  assign if1.addrb = addrb;  assign if1.dib = dib;
  assign if2.ena = ena;  assign if2.rea = rea;  assign if2.wea = wea;
  assign if2.addra = addra;  assign if2.dia = dia;
  assign if2.enb = enb;  assign if2.reb = reb;  assign if2.web = web;
  assign if2.addrb = addrb;  assign if2.dib = dib;

  dp_bram_pipe #(.N(8), .B(16), .RD_LAT(1), .RDW_MODE(0), .CW(8)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  dp_bram_pipe #(.N(8), .B(16), .RD_LAT(2), .RDW_MODE(1), .CW(8)) u2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; rea = 1'b0; wea = 2'b00; addra = 8'h00; dia = 16'h0000;
    enb = 1'b0; reb = 1'b0; web = 2'b00; addrb = 8'h00; dib = 16'h0000;
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [15:0] d, input logic [1:0] we);
    idle();
    ena = 1'b1; wea = we; addra = a; dia = d;
    step();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_u1_doa", if1.doa, 0);
    chk("rst_u1_vala", if1.vala, 0);
    chk("rst_u1_valb", if1.valb, 0);
    chk("rst_u1_coll", if1.coll, 0);
    chk("rst_u1_cnt", if1.coll_cnt, 0);
    chk("rst_u2_dob", if2.dob, 0);
    chk("rst_u2_cnt", if2.coll_cnt, 0);
    rst_n = 1'b1;
    step();

    // Basic write on A, read on B
    wr_a(8'h10, 16'hBEEF, 2'b11);
    enb = 1'b1; reb = 1'b1; addrb = 8'h10;
    step();
    idle();
    chk("t1_u1_valb", if1.valb, 1);
    chk("t1_u1_dob", if1.dob, 16'hBEEF);
    chk("t1_u1_vala", if1.vala, 0);
    chk("t1_u2_valb_early", if2.valb, 0);
    step();
    chk("t1_u1_valb_pulse", if1.valb, 0);
    chk("t1_u2_valb", if2.valb, 1);
    chk("t1_u2_dob", if2.dob, 16'hBEEF);
    step();
    chk("t1_u2_valb_pulse", if2.valb, 0);
    chk("t1_u2_dob_hold", if2.dob, 16'hBEEF);

    // Byte enables
    wr_a(8'h20, 16'h1234, 2'b11);
    wr_a(8'h20, 16'hAB00, 2'b10);
    ena = 1'b1; rea = 1'b1; addra = 8'h20;
    step();
    idle();
    chk("t2_u1_doa", if1.doa, 16'hAB34);
    chk("t2_u1_vala", if1.vala, 1);
    chk("t2_u2_vala_early", if2.vala, 0);
    step();
    chk("t2_u2_doa", if2.doa, 16'hAB34);
    chk("t2_u2_vala", if2.vala, 1);

    // Same-port read-during-write
    wr_a(8'h05, 16'h1111, 2'b11);
    ena = 1'b1; rea = 1'b1; wea = 2'b11; addra = 8'h05; dia = 16'h2222;
    step();
    idle();
    chk("t3_u1_rdw_old", if1.doa, 16'h1111);
    step();
    chk("t3_u2_rdw_new", if2.doa, 16'h2222);
    ena = 1'b1; rea = 1'b1; addra = 8'h05;
    step();
    idle();
    chk("t3_u1_after", if1.doa, 16'h2222);
    step();
    chk("t3_u2_after", if2.doa, 16'h2222);

    // Write collision with lane priority
    wr_a(8'h30, 16'h0000, 2'b11);
    chk("t4_no_coll_single", if1.coll, 0);
    ena = 1'b1; wea = 2'b01; addra = 8'h30; dia = 16'h00AA;
    enb = 1'b1; web = 2'b11; addrb = 8'h30; dib = 16'hBBCC;
    step();
    idle();
    chk("t4_u1_coll", if1.coll, 1);
    chk("t4_u1_cnt", if1.coll_cnt, 1);
    chk("t4_u2_cnt", if2.coll_cnt, 1);
    // Both ports only reading the same address is not a collision
    ena = 1'b1; rea = 1'b1; addra = 8'h30;
    enb = 1'b1; reb = 1'b1; addrb = 8'h30;
    step();
    idle();
    chk("t4_u1_coll_pulse", if1.coll, 0);
    chk("t4_u1_doa", if1.doa, 16'hBBAA);
    chk("t4_u1_dob", if1.dob, 16'hBBAA);
    chk("t4_u1_cnt_hold", if1.coll_cnt, 1);
    step();
    chk("t4_u2_doa", if2.doa, 16'hBBAA);
    chk("t4_u2_coll_rd", if2.coll, 0);

    // Counter saturation: 1 + 253 + 47 collisions
    ena = 1'b1; wea = 2'b11; addra = 8'h40; dia = 16'h4444;
    enb = 1'b1; web = 2'b01; addrb = 8'h40; dib = 16'h5555;
    repeat (253) step();
    chk("t4_cnt_254", if1.coll_cnt, 8'hFE);
    repeat (47) step();
    idle();
    chk("t4_u1_cnt_sat", if1.coll_cnt, 8'hFF);
    chk("t4_u2_cnt_sat", if2.coll_cnt, 8'hFF);
    step();
    chk("t4_cnt_sat_hold", if1.coll_cnt, 8'hFF);
    chk("t4_coll_clear", if1.coll, 0);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) wr_a(8'(i), 16'h00A0 + 16'(i), 2'b11);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b1; rea = 1'b1; addra = 8'(i);
      step();
      chk("t5_u1_vala", if1.vala, 1);
      chk("t5_u1_doa", if1.doa, 16'h00A0 + 16'(i));
      if (i == 0) begin
        chk("t5_u2_vala_first", if2.vala, 0);
      end else begin
        chk("t5_u2_vala", if2.vala, 1);
        chk("t5_u2_doa", if2.doa, 16'h00A0 + 16'(i - 1));
      end
    end
    idle();
    step();
    chk("t5_u1_vala_end", if1.vala, 0);
    chk("t5_u2_vala_last", if2.vala, 1);
    chk("t5_u2_doa_last", if2.doa, 16'h00A3);
    step();
    chk("t5_u2_vala_end", if2.vala, 0);
    chk("t5_u2_doa_hold", if2.doa, 16'h00A3);

    // Reset between accept and output
    ena = 1'b1; rea = 1'b1; addra = 8'h10;
    step();
    idle();
    chk("t6_u1_vala", if1.vala, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_u2_vala_rst", if2.vala, 0);
    chk("t6_u2_doa_rst", if2.doa, 0);
    chk("t6_u1_doa_rst", if1.doa, 0);
    chk("t6_u2_cnt_rst", if2.coll_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("t6_u2_no_valid", if2.vala, 0);
    chk("t6_u2_doa_zero", if2.doa, 0);
    step();
    chk("t6_u2_no_valid2", if2.vala, 0);
    ena = 1'b1; rea = 1'b1; addra = 8'h10;
    enb = 1'b1; reb = 1'b1; addrb = 8'h30;
    step();
    idle();
    chk("t6_u1_doa_keep", if1.doa, 16'hBEEF);
    chk("t6_u1_dob_keep", if1.dob, 16'hBBAA);
    step();
    chk("t6_u2_doa_keep", if2.doa, 16'hBEEF);
    chk("t6_u2_vala_keep", if2.vala, 1);
    chk("t6_u2_cnt_zero", if2.coll_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dp_bram_pipe.md
Name: dp_bram_pipe

Overview:
Single-clock true dual-port block RAM with per-byte write enables, selectable read latency of 1 or 2 cycles, and selectable read-during-write mode.
Read data is qualified by per-port valid pulses. Address collisions between the ports are detected, and port A has priority on conflicting writes.
Serves as the shared buffer between producer and consumer datapaths in one clock domain, replacing unqualified dual-clock RAMs where timing closure needs an output register.

Parameters:
N, 8, address width; depth = 2**N words
B, 16, data width; must be a multiple of 8; NBYTE = B/8 byte lanes
RD_LAT, 1, read latency in cycles; only 1 or 2 are legal
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data)
CW, 8, width of the collision counter

Ports:
clk  in  1  clock; all activity on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  port A enable; when low, rea and wea are ignored
rea  in  1  port A read request
wea  in  NBYTE  port A byte write enables; bit i writes dia[8i+7:8i]
addra  in  N  port A address
dia  in  B  port A write data
enb  in  1  port B enable
reb  in  1  port B read request
web  in  NBYTE  port B byte write enables
addrb  in  N  port B address
dib  in  B  port B write data
doa  out  B  port A read data
vala  out  1  port A read data valid, one-cycle pulse
dob  out  B  port B read data
valb  out  1  port B read data valid, one-cycle pulse
coll  out  1  one-cycle pulse for an address collision in the previous cycle
coll_cnt  out  CW  saturating count of collisions since reset

Behaviour:
- Reset (rst_n low, async): doa, dob, vala, valb, coll and coll_cnt are all 0; all internal read pipeline stages and valids are cleared.
- Memory array is never reset; contents persist across reset. No write occurs on any edge while rst_n is low.
- Port accept: a read is accepted when en & re; a write is accepted per lane when en & we[i]. A read and a write may both be accepted on the same port in the same cycle.
- Read latency, RD_LAT=1: data on doa (dob) and vala (valb)=1 at the first edge after accept.
- Read latency, RD_LAT=2: data and valid appear one edge later via the output register. Back-to-back reads deliver one result per cycle.
- doa/dob hold their last value when no read completes; vala/valb are high for exactly one cycle per accepted read.
- Same-port read-during-write, RDW_MODE=0: the read returns the pre-write word.
- Same-port read-during-write, RDW_MODE=1: the read returns the word after this cycle's byte merge. Unwritten lanes keep their old bytes.
- Cross-port read of an address the other port writes in the same cycle: always returns the old word, regardless of RDW_MODE.
- Same-address writes from both ports, per lane:
  - lanes enabled by both ports take port A data;
  - lanes enabled by only one port take that port's data;
  - lanes enabled by neither port are unchanged.
- Collision: ena & enb & (addra==addrb) & (|wea | |web). Reads alone never collide.
  - coll pulses high on the next edge.
  - coll_cnt increments by 1 and saturates at 2**CW-1 (no wrap).
- Address is used as-is; depth is always 2**N, so there is no out-of-range case.
- Reset asserted mid-read: pending results are discarded and no valid is emitted after rst_n rises.
- Elaboration: illegal RD_LAT or B%8 != 0 is an error, reported via a generate-time $error.

Test Plan:
- Reset/basic, RD_LAT=1: write A addr 0x10 = 0xBEEF (wea=2'b11); read B addr 0x10 next cycle -> dob=0xBEEF, valb=1 exactly 1 cycle after accept; vala stays 0.
- Byte enables: mem[0x20]=0x1234; A writes 0xAB00 with wea=2'b10 -> subsequent read = 0xAB34.
- RDW modes: mem[0x05]=0x1111; A reads and writes 0x2222 to 0x05 in the same cycle.
  - RDW_MODE=0 -> doa=0x1111; RDW_MODE=1 -> doa=0x2222.
  - A later read returns 0x2222 in both modes.
- Write collision: mem[0x30]=0x0000; same cycle, A writes 0x00AA with wea=2'b01 and B writes 0xBBCC with web=2'b11 to 0x30.
  - mem[0x30] becomes 0xBBAA.
  - coll pulses once; coll_cnt=1.
  - Drive 300 collisions with CW=8 -> coll_cnt=255.
- RD_LAT=2 streaming: 4 back-to-back reads on A of addrs 0..3 (preloaded 0xA0..0xA3) -> vala high for 4 consecutive cycles starting 2 edges after the first accept; data 0xA0..0xA3 in order.
- Reset mid-read: pulse rst_n low between accept and output (RD_LAT=2) -> vala never asserts for that read, doa=0, coll_cnt=0; previously written data is still readable afterwards.
